// File: rtl/imem_port0_ctrl_if.sv
// Wishbone slave bundle between the user-wrapper bus and imem_port0_ctrl.
interface imem_port0_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/imem_port0_ctrl.sv
// Port-0 owner of the instruction SRAM: arbitrates Wishbone and LA loader, holds core in reset.
// Optional IMEM_CHECKSUM_EN builds a running checksum of written words at offset 0x808.
module imem_port0_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned ADDR_W       = 9,
  parameter bit          HOLD_RST_VAL = 1'b1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  imem_port0_ctrl_if.slave  wb,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic [ADDR_W-1:0] la_addr_i,
  input  logic [31:0]       la_data_i,
  output logic [31:0]       la_rdata_o,
  output logic              la_done_o,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [31:0]       din0,
  input  logic [31:0]       dout0,
  output logic              core_rst_o
);
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;
  localparam logic [9:0]  OFS_CTRL   = 10'h200;
  localparam logic [9:0]  OFS_STATUS = 10'h201;
  localparam logic [9:0]  OFS_CSUM   = 10'h202;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDW, S_ACK} state_e;

  state_e            state_q, state_d;
  logic              grant_la_q, grant_la_d;
  logic              last_la_q, last_la_d;
  logic              hold_q, hold_d, la_en_q, la_en_d, wr_err_q, wr_err_d;
  logic              la_pend_q, la_pend_d, la_req_q, la_req_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic              csb0_q, csb0_d, web0_q, web0_d;
  logic [MW-1:0]     wmask0_q, wmask0_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [DW-1:0]     din0_q, din0_d, wbs_dat_o_q, wbs_dat_o_d, la_rdata_q, la_rdata_d;

  logic              wb_req, la_req, pick_la, acc_we, acc_mem, wr_err_set, csum_clr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DW-1:0]     acc_data, reg_rdata, csum_rd;
  logic [MW-1:0]     acc_mask;
  logic              unused_adr;

  assign unused_adr = ^wb.wbs_adr_i[1:0];
  assign wb_req     = wb.wbs_stb_i & wb.wbs_cyc_i & (wb.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign la_req     = la_pend_q & la_en_q;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d     = state_q;
    grant_la_d  = grant_la_q;
    last_la_d   = last_la_q;
    hold_d      = hold_q;
    la_en_d     = la_en_q;
    wr_err_d    = wr_err_q;
    la_pend_d   = la_pend_q;
    la_req_d    = la_req_i;
    wr_count_d  = wr_count_q;
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    wmask0_d    = wmask0_q;
    addr0_d     = addr0_q;
    din0_d      = din0_q;
    wbs_dat_o_d = wbs_dat_o_q;
    la_rdata_d  = la_rdata_q;
    wr_err_set  = 1'b0;
    csum_clr    = 1'b0;
    pick_la     = 1'b0;
    acc_we      = wb.wbs_we_i;
    acc_mem     = ~wb.wbs_adr_i[11];
    acc_addr    = wb.wbs_adr_i[ADDR_W+1:2];
    acc_data    = wb.wbs_dat_i;
    acc_mask    = wb.wbs_sel_i;

    case (wb.wbs_adr_i[11:2])
      OFS_CTRL:   reg_rdata = DW'({wr_err_q, la_en_q, hold_q});
      OFS_STATUS: reg_rdata = DW'(wr_count_q);
      OFS_CSUM:   reg_rdata = csum_rd;
      default:    reg_rdata = '0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (wb_req || la_req) begin
          // On contention the requester that did not win last time goes first
          pick_la    = la_req && (!wb_req || !last_la_q);
          grant_la_d = pick_la;
          last_la_d  = pick_la;
          if (pick_la) begin
            la_pend_d = 1'b0;
            acc_we    = la_we_i;
            acc_mem   = 1'b1;
            acc_addr  = la_addr_i;
            acc_data  = la_data_i;
            acc_mask  = '1;
          end
          if (!acc_mem) begin
            state_d = S_ACK;
            if (acc_we) begin
              if (wb.wbs_adr_i[11:2] == OFS_CTRL) begin
                hold_d   = acc_data[0];
                la_en_d  = acc_data[1];
                csum_clr = acc_data[3];
                if (acc_data[2]) wr_err_d = 1'b0;
              end
            end else begin
              wbs_dat_o_d = reg_rdata;
            end
          end else if (acc_we) begin
            if (hold_q) begin
              state_d  = S_WR;
              csb0_d   = 1'b0;
              web0_d   = 1'b0;
              addr0_d  = acc_addr;
              din0_d   = acc_data;
              wmask0_d = acc_mask;
            end else begin
              state_d    = S_ACK;
              wr_err_set = 1'b1;
            end
          end else begin
            state_d = S_RD;
            csb0_d  = 1'b0;
            addr0_d = acc_addr;
          end
        end
      end
      S_WR: begin
        state_d    = S_ACK;
        wr_count_d = wr_count_q + 16'd1;
      end
      S_RD:  state_d = S_RDW;
      S_RDW: begin
        state_d = S_ACK;
        if (grant_la_q) la_rdata_d = dout0;
        else            wbs_dat_o_d = dout0;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_err_set) wr_err_d = 1'b1;
    if (la_req_i && !la_req_q && la_en_q) la_pend_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      grant_la_q  <= 1'b0;
      last_la_q   <= 1'b1;
      hold_q      <= HOLD_RST_VAL;
      la_en_q     <= 1'b0;
      wr_err_q    <= 1'b0;
      la_pend_q   <= 1'b0;
      la_req_q    <= 1'b0;
      wr_count_q  <= '0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      wmask0_q    <= '0;
      addr0_q     <= '0;
      din0_q      <= '0;
      wbs_dat_o_q <= '0;
      la_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_la_q  <= grant_la_d;
      last_la_q   <= last_la_d;
      hold_q      <= hold_d;
      la_en_q     <= la_en_d;
      wr_err_q    <= wr_err_d;
      la_pend_q   <= la_pend_d;
      la_req_q    <= la_req_d;
      wr_count_q  <= wr_count_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      wmask0_q    <= wmask0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      wbs_dat_o_q <= wbs_dat_o_d;
      la_rdata_q  <= la_rdata_d;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d, wmask_bits;

  // Accumulate the bytes actually written; a clear overrides a same-cycle add
  always_comb begin
    csum_d     = csum_q;
    wmask_bits = '0;
    for (int b = 0; b < int'(MW); b++) wmask_bits[8*b +: 8] = {8{wmask0_q[b]}};
    if (state_q == S_WR) csum_d = csum_q + (din0_q & wmask_bits);
    if (csum_clr) csum_d = '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign csum_rd = csum_q;
`else
  logic unused_csum_clr;
  assign unused_csum_clr = csum_clr;
  assign csum_rd         = '0;
`endif

  assign wb.wbs_ack_o = (state_q == S_ACK) & ~grant_la_q & wb.wbs_cyc_i & wb.wbs_stb_i;
  assign wb.wbs_dat_o = wbs_dat_o_q;
  assign la_rdata_o   = la_rdata_q;
  assign la_done_o    = (state_q == S_ACK) & grant_la_q;
  assign csb0         = csb0_q;
  assign web0         = web0_q;
  assign wmask0       = wmask0_q;
  assign addr0        = addr0_q;
  assign din0         = din0_q;
  assign core_rst_o   = hold_q | wb_rst_i;
endmodule

// File: tb/tb_imem_port0_ctrl.sv
// Self-checking bench for imem_port0_ctrl: SRAM model, spec-level reference model, directed + random steps.
module tb_imem_port0_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        la_req, la_we, la_done, csb0, web0, core_rst;
  logic [8:0]  la_addr, addr0;
  logic [31:0] la_data, la_rdata, din0, dout0;
  logic [3:0]  wmask0;

  imem_port0_ctrl_if wbif ();

  imem_port0_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(wbif),
    .la_req_i(la_req), .la_we_i(la_we), .la_addr_i(la_addr), .la_data_i(la_data),
    .la_rdata_o(la_rdata), .la_done_o(la_done),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .core_rst_o(core_rst)
  );

  always #5 clk = ~clk;

  // 32x512 SRAM with one-cycle read latency
  logic [31:0] sram [512];
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++) if (wmask0[b]) sram[addr0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= sram[addr0];
      end
    end
  end

  int         csb_low_total = 0;
  int         la_done_total = 0;
  logic [8:0] mon_addr;
  logic [3:0] mon_mask;
  logic       mon_we;
  always @(negedge clk) begin
    if (!csb0) begin
      csb_low_total <= csb_low_total + 1;
      mon_addr      <= addr0;
      mon_mask      <= wmask0;
      mon_we        <= !web0;
    end
    if (la_done) la_done_total <= la_done_total + 1;
  end

  // Reference model state
  logic [31:0] ref_mem [512];
  logic        m_hold, m_la_en, m_err;
  logic [15:0] m_cnt;
  logic [31:0] m_csum;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_val();
    return {28'b0, 1'b0, m_err, m_la_en, m_hold};
  endfunction

  function automatic logic [31:0] csum_exp();
`ifdef IMEM_CHECKSUM_EN
    return m_csum;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_write(input int word, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    if (m_hold) begin
      m = '0;
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
      ref_mem[word] = (ref_mem[word] & ~m) | (d & m);
      m_csum = m_csum + (d & m);
      m_cnt  = m_cnt + 16'd1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b1; m_la_en = 1'b0; m_err = 1'b0; m_cnt = '0; m_csum = '0;
  endtask

  // Drives one Wishbone access from a negedge; lat = cycles from sampling edge to ack (0 = timeout)
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int lat);
    wbif.wbs_cyc_i = 1'b1; wbif.wbs_stb_i = 1'b1; wbif.wbs_we_i = we;
    wbif.wbs_adr_i = adr;  wbif.wbs_dat_i = d;    wbif.wbs_sel_i = s;
    lat = 0; rd = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (wbif.wbs_ack_o) begin lat = k; rd = wbif.wbs_dat_o; break; end
    end
    wbif.wbs_cyc_i = 1'b0; wbif.wbs_stb_i = 1'b0; wbif.wbs_we_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_rd(input logic [31:0] adr, input logic [31:0] exp, input int exp_lat, input string tag);
    logic [31:0] rd; int lat;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, rd, lat);
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "/data"}, rd, exp);
  endtask

  task automatic ctrl_wr(input logic [31:0] d);
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, BASE + 32'h800, d, 4'hF, rd, lat);
    check("ctrl_wr/lat", 32'(lat), 32'd1);
    m_hold = d[0]; m_la_en = d[1];
    if (d[2]) m_err = 1'b0;
    if (d[3]) m_csum = '0;
  endtask

  task automatic mem_wr(input int word, input logic [31:0] d, input logic [3:0] s, input string tag);
    logic [31:0] rd; int lat, c0; logic will;
    will = m_hold; c0 = csb_low_total;
    wb_xfer(1'b1, BASE + (32'(word) << 2), d, s, rd, lat);
    model_write(word, d, s);
    check({tag, "/lat"}, 32'(lat), will ? 32'd2 : 32'd1);
    check({tag, "/csb_cycles"}, 32'(csb_low_total - c0), will ? 32'd1 : 32'd0);
    if (will) begin
      check({tag, "/addr0"}, 32'(mon_addr), 32'(word));
      check({tag, "/wmask0"}, 32'(mon_mask), 32'(s));
      check({tag, "/web0"}, 32'(mon_we), 32'd1);
    end
  endtask

  task automatic mem_rd(input int word, input string tag);
    wb_rd(BASE + (32'(word) << 2), ref_mem[word], 3, tag);
  endtask

  task automatic la_xfer(input logic we, input logic [8:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int cyc);
    la_we = we; la_addr = a; la_data = d; la_req = 1'b1;
    cyc = 0; rd = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (la_done) begin cyc = k; rd = la_rdata; break; end
    end
    la_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd, old9;
    int          lat, c0, d0, acks, op, word;
    logic        wb_seen, la_seen, wb_first;

    for (int i = 0; i < 512; i++) begin sram[i] <= '0; ref_mem[i] = '0; end
    model_reset();
    rst = 1'b1; la_req = 0; la_we = 0; la_addr = '0; la_data = '0;
    wbif.wbs_cyc_i = 0; wbif.wbs_stb_i = 0; wbif.wbs_we_i = 0;
    wbif.wbs_sel_i = '0; wbif.wbs_adr_i = '0; wbif.wbs_dat_i = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst/csb0", 32'(csb0), 32'd1);
    check("rst/web0", 32'(web0), 32'd1);
    check("rst/wmask0", 32'(wmask0), 32'd0);
    check("rst/addr0", 32'(addr0), 32'd0);
    check("rst/din0", din0, 32'd0);
    check("rst/ack", 32'(wbif.wbs_ack_o), 32'd0);
    check("rst/dat_o", wbif.wbs_dat_o, 32'd0);
    check("rst/la_rdata", la_rdata, 32'd0);
    check("rst/la_done", 32'(la_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst/core_rst", 32'(core_rst), 32'd1);
    wb_rd(BASE + 32'h800, ctrl_val(), 1, "ctrl_after_rst");

    // Basic write / readback / status
    mem_wr(4, 32'hDEADBEEF, 4'hF, "wr_deadbeef");
    mem_rd(4, "rd_deadbeef");
    wb_rd(BASE + 32'h804, {16'b0, m_cnt}, 1, "status_1");
    wb_rd(BASE + 32'h80C, 32'h0, 1, "unmapped_reg");

    // Write protection with HOLD off
    ctrl_wr(32'h0);
    check("hold_off/core_rst", 32'(core_rst), 32'd0);
    mem_wr(0, 32'h11111111, 4'hF, "wr_protected");
    wb_rd(BASE + 32'h800, ctrl_val(), 1, "ctrl_wr_err");
    ctrl_wr(32'h4);
    wb_rd(BASE + 32'h800, ctrl_val(), 1, "ctrl_err_clr");

    // LA write posted alongside a WB read of the same word
    ctrl_wr(32'h3);
    old9 = ref_mem[9];
    d0 = la_done_total;
    la_we = 1'b1; la_addr = 9'd9; la_data = 32'h12345678; la_req = 1'b1;
    wbif.wbs_cyc_i = 1'b1; wbif.wbs_stb_i = 1'b1; wbif.wbs_we_i = 1'b0;
    wbif.wbs_adr_i = BASE + 32'h24; wbif.wbs_sel_i = 4'hF;
    wb_seen = 0; la_seen = 0; wb_first = 0; rd = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (wbif.wbs_ack_o && !wb_seen) begin
        wb_seen = 1; rd = wbif.wbs_dat_o; wb_first = !la_seen;
        wbif.wbs_cyc_i = 1'b0; wbif.wbs_stb_i = 1'b0;
      end
      if (la_done && !la_seen) begin la_seen = 1; la_req = 1'b0; end
      if (wb_seen && la_seen) break;
    end
    @(negedge clk);
    model_write(9, 32'h12345678, 4'hF);
    check("arb/wb_acked", 32'(wb_seen), 32'd1);
    check("arb/la_done", 32'(la_seen), 32'd1);
    check("arb/wb_first", 32'(wb_first), 32'd1);
    check("arb/old_data", rd, old9);
    check("arb/la_done_pulses", 32'(la_done_total - d0), 32'd1);
    mem_rd(9, "rd_after_la");
    la_xfer(1'b0, 9'd9, 32'h0, rd, lat);
    check("la_rd/done", 32'(lat != 0), 32'd1);
    check("la_rd/data", rd, ref_mem[9]);

    // Partial byte write and checksum
    mem_wr(20, 32'hFFFFFFFF, 4'hF, "wr_ones");
    ctrl_wr(32'h9);
    mem_wr(20, 32'hAABBCCDD, 4'b0011, "wr_sel3");
    mem_rd(20, "rd_sel3");
    check("sel3/const", ref_mem[20], 32'hFFFFCCDD);
    wb_rd(BASE + 32'h808, csum_exp(), 1, "csum");

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      op   = $urandom_range(0, 3);
      word = (op == 3) ? $urandom_range(0, 511) : $urandom_range(0, 15);
      case (op)
        0, 1: mem_wr(word, $urandom, 4'($urandom_range(1, 15)), "rnd_wr");
        2:    mem_rd(word, "rnd_rd");
        default: begin
          mem_rd(word, "rnd_rd_any");
          wb_rd(BASE + 32'h804, {16'b0, m_cnt}, 1, "rnd_status");
        end
      endcase
    end
    wb_rd(BASE + 32'h808, csum_exp(), 1, "csum_end");

    // Non-hit address never acked
    c0 = csb_low_total; acks = 0;
    wbif.wbs_cyc_i = 1; wbif.wbs_stb_i = 1; wbif.wbs_we_i = 0; wbif.wbs_adr_i = BASE + 32'h1010;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (wbif.wbs_ack_o) acks++; end
    wbif.wbs_cyc_i = 0; wbif.wbs_stb_i = 0;
    @(negedge clk);
    check("nohit/acks", 32'(acks), 32'd0);
    check("nohit/csb", 32'(csb_low_total - c0), 32'd0);

    // Master drops cyc during RD: access completes, no ack
    c0 = csb_low_total; acks = 0;
    wbif.wbs_cyc_i = 1; wbif.wbs_stb_i = 1; wbif.wbs_we_i = 0; wbif.wbs_adr_i = BASE + 32'h10;
    @(negedge clk);
    wbif.wbs_cyc_i = 0; wbif.wbs_stb_i = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (wbif.wbs_ack_o) acks++; end
    check("cyc_drop/acks", 32'(acks), 32'd0);
    check("cyc_drop/csb", 32'(csb_low_total - c0), 32'd1);
    mem_rd(4, "rd_after_drop");

    // Reset during RDW aborts the read
    wbif.wbs_cyc_i = 1; wbif.wbs_stb_i = 1; wbif.wbs_we_i = 0; wbif.wbs_adr_i = BASE + 32'h10;
    @(negedge clk);
    @(negedge clk);
    check("rdw/no_early_ack", 32'(wbif.wbs_ack_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdw/ack", 32'(wbif.wbs_ack_o), 32'd0);
    check("rst_rdw/csb0", 32'(csb0), 32'd1);
    check("rst_rdw/dat_o", wbif.wbs_dat_o, 32'd0);
    rst = 1'b0;
    wbif.wbs_cyc_i = 0; wbif.wbs_stb_i = 0;
    @(negedge clk);
    check("rst_rdw/ack_after", 32'(wbif.wbs_ack_o), 32'd0);
    model_reset();
    wb_rd(BASE + 32'h800, ctrl_val(), 1, "ctrl_after_rst2");
    wb_rd(BASE + 32'h804, {16'b0, m_cnt}, 1, "status_after_rst2");
    mem_rd(4, "rd_after_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
